// File: rtl/detector_jogada.sv
// Player-button conditioner: 2-flop sync, debounce FSM with one pulse per press, inactivity timer.
// Optional timer is built only when DETECTOR_JOGADA_TIMEOUT_EN is defined; otherwise timeout is tied to 0.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  input  logic       zera_timeout,
  output logic       jogada,
  output logic [3:0] jogada_codigo,
  output logic       timeout,
  output logic [2:0] db_estado
);

  localparam logic [2:0] SOLTA  = 3'd0;
  localparam logic [2:0] ESPERA = 3'd1;
  localparam logic [2:0] FILTRA = 3'd2;
  localparam logic [2:0] PULSO  = 3'd3;
  localparam logic [2:0] SEGURA = 3'd4;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1_reg;
  logic [3:0]    botoes_s;
  logic          um_quente;
  logic [2:0]    state_reg, state_next;
  logic [DW-1:0] count_reg, count_next;
  logic [3:0]    candidato_reg, candidato_next;
  logic          jogada_reg, jogada_next;
  logic [3:0]    codigo_reg, codigo_next;

  // Two-flop synchronizer, one chain per button
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      always_ff @(posedge clock) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          botoes_s[gi]  <= 1'b0;
        end else begin
          sync1_reg[gi] <= botoes[gi];
          botoes_s[gi]  <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  assign um_quente = (botoes_s != 4'd0) && ((botoes_s & (botoes_s - 4'd1)) == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= SOLTA;
      count_reg     <= '0;
      candidato_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      candidato_reg <= candidato_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    candidato_next = candidato_reg;
    case (state_reg)
      SOLTA: begin
        if (botoes_s == 4'd0) begin
          if (count_reg == DB_LAST) begin
            state_next = ESPERA;
            count_next = '0;
          end else begin
            count_next = count_reg + DW'(1);
          end
        end else begin
          count_next = '0;
        end
      end
      ESPERA: begin
        if (um_quente) begin
          candidato_next = botoes_s;
          count_next     = '0;
          state_next     = FILTRA;
        end
      end
      FILTRA: begin
        if (botoes_s == candidato_reg) begin
          if (count_reg == DB_LAST) begin
            state_next = PULSO;
            count_next = '0;
          end else begin
            count_next = count_reg + DW'(1);
          end
        end else if (um_quente) begin
          // A different single button restarts the filter on the new candidate
          candidato_next = botoes_s;
          count_next     = '0;
        end else begin
          state_next = ESPERA;
          count_next = '0;
        end
      end
      PULSO: begin
        state_next = SEGURA;
      end
      SEGURA: begin
        if (botoes_s == 4'd0) begin
          state_next = SOLTA;
          count_next = '0;
        end
      end
      default: begin
        state_next = SOLTA;
        count_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so jogada lines up with the PULSO cycle
  always_comb begin
    jogada_next = (state_next == PULSO);
    codigo_next = codigo_reg;
    if (state_next == PULSO) begin
      codigo_next = candidato_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      jogada_reg <= 1'b0;
      codigo_reg <= 4'd0;
    end else begin
      jogada_reg <= jogada_next;
      codigo_reg <= codigo_next;
    end
  end

  assign jogada        = jogada_reg;
  assign jogada_codigo = codigo_reg;
  assign db_estado     = state_reg;

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tempo_reg;
  logic          timeout_reg;

  // Clear sources outrank the terminal-count set, so a press on the last cycle wins
  always_ff @(posedge clock) begin
    if (reset) begin
      tempo_reg   <= '0;
      timeout_reg <= 1'b0;
    end else if (zera_timeout) begin
      tempo_reg   <= '0;
      timeout_reg <= 1'b0;
    end else if (state_reg == PULSO) begin
      tempo_reg <= '0;
    end else if (habilita && !timeout_reg) begin
      if (tempo_reg == TO_LAST) begin
        timeout_reg <= 1'b1;
      end else begin
        tempo_reg <= tempo_reg + TW'(1);
      end
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_timer;
  assign unused_timer = habilita ^ zera_timeout;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: stimulus table, hand-written corner sequences and random traffic,
// all compared every cycle against a run-length reference model of the press/release rules.
module tb_detector_jogada;

  localparam int DB = 4;
  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'd0;
  logic       habilita = 1'b0;
  logic       zera_timeout = 1'b0;
  logic       jogada;
  logic [3:0] jogada_codigo;
  logic       timeout;
  logic [2:0] db_estado;

  detector_jogada #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .habilita     (habilita),
    .zera_timeout (zera_timeout),
    .jogada       (jogada),
    .jogada_codigo(jogada_codigo),
    .timeout      (timeout),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses_seen = 0;

  // Reference model: sampled-value history expressed as run lengths
  logic [3:0] m_s1, m_s2, m_val, m_code;
  int         m_phase;  // 0 wait any zero, 1 count zeros, 2 armed, 3 pulse cycle
  int         m_zrun, m_run, m_cnt;
  logic       m_jog, m_to;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] smp;
    logic       pulse;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_val = 0; m_code = 0;
      m_phase = 1; m_zrun = 0; m_run = 0; m_cnt = 0;
      m_jog = 0; m_to = 0;
      return;
    end
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = botoes;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    if (zera_timeout) begin
      m_cnt = 0; m_to = 0;
    end else if (m_jog) begin
      m_cnt = 0;
    end else if (habilita && !m_to) begin
      if (m_cnt == TO - 1) m_to = 1;
      else m_cnt++;
    end
`endif
    pulse = 0;
    case (m_phase)
      3: m_phase = 0;
      0: if (smp == 0) begin m_phase = 1; m_zrun = 0; end
      1: begin
        if (smp == 0) begin
          m_zrun++;
          if (m_zrun == DB) begin m_phase = 2; m_run = 0; end
        end else begin
          m_zrun = 0;
        end
      end
      default: begin
        if ($onehot(smp)) begin
          if (m_run > 0 && smp == m_val) m_run++;
          else begin m_val = smp; m_run = 1; end
        end else begin
          m_run = 0;
        end
        if (m_run == DB + 1) begin
          pulse = 1; m_code = m_val; m_phase = 3;
        end
      end
    endcase
    m_jog = pulse;
  endtask

  task automatic cycle(input logic [3:0] b, input logic h, input logic z, input logic r);
    botoes = b; habilita = h; zera_timeout = z; reset = r;
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    if (jogada === 1'b1) pulses_seen++;
    chk("jogada", jogada, m_jog);
    chk("codigo", jogada_codigo, m_code);
    chk("timeout", timeout, m_to);
    if (m_jog) chk("estado_pulso", db_estado, 3);
    if (r) chk("estado_reset", db_estado, 0);
  endtask

  typedef struct {
    logic [3:0] b;
    logic       rst;
    int         n;
    int         pulses;
    logic [3:0] code;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic [3:0] b, logic rst, int n, int p, logic [3:0] c);
    vec_t v;
    v.b = b; v.rst = rst; v.n = n; v.pulses = p; v.code = c;
    return v;
  endfunction

  initial begin
    int first;
    int rise;
    // Segments: buttons held for n cycles, pulses expected in the segment, code afterwards
    tab.push_back(mk(4'b0000, 1, 2, 0, 4'b0000));
    tab.push_back(mk(4'b0000, 0, 6, 0, 4'b0000));
    tab.push_back(mk(4'b0100, 0, 10, 1, 4'b0100));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b0100));
    for (int i = 0; i < 3; i++) begin
      tab.push_back(mk(4'b0001, 0, 2, 0, 4'b0100));
      tab.push_back(mk(4'b0000, 0, 2, 0, 4'b0100));
    end
    tab.push_back(mk(4'b0001, 0, 10, 1, 4'b0001));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b0001));
    tab.push_back(mk(4'b0011, 0, 10, 0, 4'b0001));
    tab.push_back(mk(4'b0010, 0, 2, 0, 4'b0001));
    tab.push_back(mk(4'b1000, 0, 10, 1, 4'b1000));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b1000));
    tab.push_back(mk(4'b0001, 0, 50, 1, 4'b0001));
    tab.push_back(mk(4'b0000, 0, 2, 0, 4'b0001));
    tab.push_back(mk(4'b0010, 0, 10, 0, 4'b0001));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b0001));
    tab.push_back(mk(4'b0010, 0, 10, 1, 4'b0010));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b0010));
    tab.push_back(mk(4'b0100, 0, 4, 0, 4'b0010));
    tab.push_back(mk(4'b0100, 1, 2, 0, 4'b0000));
    tab.push_back(mk(4'b0100, 0, 20, 0, 4'b0000));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b0000));
    tab.push_back(mk(4'b0100, 0, 10, 1, 4'b0100));
    tab.push_back(mk(4'b0000, 0, 8, 0, 4'b0100));

    foreach (tab[i]) begin
      pulses_seen = 0;
      for (int c = 0; c < tab[i].n; c++) cycle(tab[i].b, 1'b0, 1'b0, tab[i].rst);
      chk("vec_pulses", pulses_seen, tab[i].pulses);
      chk("vec_codigo", jogada_codigo, tab[i].code);
      chk("vec_timeout", timeout, 0);
      $display("vec %0d b=%b rst=%b n=%0d pulses=%0d codigo=%b", i, tab[i].b, tab[i].rst,
               tab[i].n, pulses_seen, jogada_codigo);
    end

    // Press latency: first stable edge is iteration 1, pulse must follow edge 7
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      if (jogada === 1'b1 && first == 0) first = i;
    end
    chk("press_latency", first, 7);
    $display("seq latency pulse_edge=%0d", first);
    repeat (8) cycle(4'b0000, 1'b0, 1'b0, 1'b0);

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    rise = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      if (timeout === 1'b1) rise = i;
    end
    chk("timeout_latency", rise, TO);
    repeat (5) cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("timeout_sticky", timeout, 1);
    pulses_seen = 0;
    repeat (10) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (8) cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("press_after_timeout_pulses", pulses_seen, 1);
    chk("press_keeps_timeout", timeout, 1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("zera_clears", timeout, 0);
    $display("seq timeout rise=%0d", rise);

    // Pulse lands on the terminal-count cycle: the clear must win
    repeat (12) cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b0100, 1'b1, 1'b0, 1'b0);
      if (jogada === 1'b1) first = i;
    end
    chk("collision_pulse_edge", first, 7);
    chk("collision_timeout", timeout, 0);
    repeat (5) cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    chk("collision_timeout_later", timeout, 0);
    $display("seq collision pulse_edge=%0d timeout=%b", first, timeout);
    repeat (8) cycle(4'b0000, 1'b0, 1'b0, 1'b0);
`endif

    // Random traffic: held values of random length, occasional zera and reset
    for (int s = 0; s < 120; s++) begin
      logic [3:0] val;
      int kind, len;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) val = 4'd0;
      else if (kind == 3) val = 4'($urandom_range(0, 15));
      else val = 4'(1 << $urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      pulses_seen = 0;
      for (int c = 0; c < len; c++) begin
        cycle(val, ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 149) == 0));
      end
      $display("rnd %0d b=%b len=%0d pulses=%0d timeout=%b", s, val, len, pulses_seen, timeout);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
